snn_decoder: RTL and testbench

- Output decoder of the SNN accelerator. It sits between the output AER link of the neuromorphic core and the host/control interface.
- Acts as a 4-phase AER receiver: it acknowledges every output spike event.
- Latches the address of the first spike received after each image start as the inferred class/digit, and raises an interrupt.
- Later spikes of the same image are acknowledged and discarded.

---
 rtl/snn_pkg.sv | 10 +
 rtl/aer_rx_handshake.sv | 40 ++++
 rtl/snn_decoder.sv | 49 ++++
 tb/tb_snn_decoder.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/snn_pkg.sv
// Shared constants and handshake state type for the SNN output decoder.
package snn_pkg;
  localparam int N_OUT = 256;
  localparam int M_OUT = $clog2(N_OUT);

  typedef enum logic {
    IDLE   = 1'b0,
    ACKING = 1'b1
  } aer_rx_state_t;
endpackage

// File: rtl/aer_rx_handshake.sv
// 4-phase AER slave: acknowledges each request and flags the cycle on which
// a new event is accepted so the address can be sampled on that same edge.
module aer_rx_handshake
  import snn_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic req,
  output logic ack,
  output logic capture_strobe
);

  aer_rx_state_t state_reg;
  aer_rx_state_t state_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (req)  state_next = ACKING;
      ACKING:  if (!req) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // ack decodes the state register directly, so it is glitch-free and
  // rises/falls one cycle after the corresponding REQ edge.
  always_comb begin
    ack            = (state_reg == ACKING);
    capture_strobe = (state_reg == IDLE) && req;
  end

endmodule

// File: rtl/snn_decoder.sv
// Output decoder: acknowledges every output spike and latches the address of
// the first spike after each image start as the inferred digit.
module snn_decoder
  import snn_pkg::*;
(
  input  logic             CLK,
  input  logic             RST,
  input  logic             NEW_IMAGE,
  input  logic [M_OUT-1:0] AEROUT_ADDR,
  input  logic             AEROUT_REQ,
  output logic             AEROUT_ACK,
  output logic             INFERENCE_DONE,
  output logic [M_OUT-1:0] INFERED_DIGIT
);

  logic             capture_strobe;
  logic             armed_reg;
  logic             done_reg;
  logic [M_OUT-1:0] digit_reg;

  aer_rx_handshake u_handshake (
    .clk            (CLK),
    .rst_n          (RST),
    .req            (AEROUT_REQ),
    .ack            (AEROUT_ACK),
    .capture_strobe (capture_strobe)
  );

  // NEW_IMAGE outranks a coincident capture: that event is dropped and the
  // decoder stays armed for the next one.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      armed_reg <= 1'b1;
      done_reg  <= 1'b0;
      digit_reg <= '0;
    end else if (NEW_IMAGE) begin
      armed_reg <= 1'b1;
      done_reg  <= 1'b0;
    end else if (capture_strobe && armed_reg) begin
      armed_reg <= 1'b0;
      done_reg  <= 1'b1;
      digit_reg <= AEROUT_ADDR;
    end
  end

  assign INFERENCE_DONE = done_reg;
  assign INFERED_DIGIT  = digit_reg;

endmodule

// File: tb/tb_snn_decoder.sv
// Directed bench for snn_decoder: a per-cycle vector table plus a hand-written
// sequence for reset in the middle of a handshake.
module tb_snn_decoder;
  import snn_pkg::*;

  logic             CLK;
  logic             RST;
  logic             NEW_IMAGE;
  logic [M_OUT-1:0] AEROUT_ADDR;
  logic             AEROUT_REQ;
  logic             AEROUT_ACK;
  logic             INFERENCE_DONE;
  logic [M_OUT-1:0] INFERED_DIGIT;

  int tests_run;
  int tests_failed;

  typedef struct {
    logic       ni;
    logic       req;
    logic [7:0] addr;
    logic       exp_ack;
    logic       exp_done;
    logic [7:0] exp_digit;
  } vec_t;

  vec_t vecs[$];

  snn_decoder dut (
    .CLK            (CLK),
    .RST            (RST),
    .NEW_IMAGE      (NEW_IMAGE),
    .AEROUT_ADDR    (AEROUT_ADDR),
    .AEROUT_REQ     (AEROUT_REQ),
    .AEROUT_ACK     (AEROUT_ACK),
    .INFERENCE_DONE (INFERENCE_DONE),
    .INFERED_DIGIT  (INFERED_DIGIT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s step %0d: got %0d, expected %0d", name, idx, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input int idx, input logic ack, input logic done, input logic [7:0] dig);
    check({tag, ".ack"}, idx, {7'd0, AEROUT_ACK}, {7'd0, ack});
    check({tag, ".done"}, idx, {7'd0, INFERENCE_DONE}, {7'd0, done});
    check({tag, ".digit"}, idx, INFERED_DIGIT, dig);
    $display("[TB] %s step %0d: ni=%0b req=%0b addr=%0d -> ack=%0b done=%0b digit=%0d",
             tag, idx, NEW_IMAGE, AEROUT_REQ, AEROUT_ADDR, AEROUT_ACK, INFERENCE_DONE, INFERED_DIGIT);
  endtask

  task automatic add(input logic ni, input logic req, input logic [7:0] addr,
                     input logic ack, input logic done, input logic [7:0] dig);
    vec_t v;
    v.ni = ni; v.req = req; v.addr = addr;
    v.exp_ack = ack; v.exp_done = done; v.exp_digit = dig;
    vecs.push_back(v);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;

    // Expected outputs are those visible just after the edge that samples the inputs.
    add(0, 1,  1, 1, 1,  1);  // first spike after reset captured
    add(0, 0,  1, 0, 1,  1);
    add(0, 0,  0, 0, 1,  1);
    add(0, 1,  3, 1, 1,  1);  // second spike same image ignored
    add(0, 0,  3, 0, 1,  1);
    add(1, 0,  0, 0, 0,  1);  // NEW_IMAGE pulse: done clears, digit kept
    add(0, 1,  2, 1, 1,  2);
    add(0, 0,  2, 0, 1,  2);
    add(0, 1,  7, 1, 1,  2);
    add(0, 0,  7, 0, 1,  2);
    add(0, 1,  9, 1, 1,  2);
    add(0, 0,  9, 0, 1,  2);
    add(0, 1,  8, 1, 1,  2);
    add(0, 0,  8, 0, 1,  2);
    add(1, 0,  0, 0, 0,  2);
    add(0, 0,  0, 0, 0,  2);  // idle cycle
    add(0, 1,  4, 1, 1,  4);
    add(0, 1,  4, 1, 1,  4);  // REQ held: stay in ACKING
    add(0, 0,  4, 0, 1,  4);
    add(0, 1,  5, 1, 1,  4);
    add(0, 0,  5, 0, 1,  4);
    add(1, 1,  6, 1, 0,  4);  // NEW_IMAGE on capture cycle wins
    add(0, 0,  6, 0, 0,  4);
    add(0, 1, 11, 1, 1, 11);
    add(0, 0, 11, 0, 1, 11);
    add(1, 1, 20, 1, 0, 11);  // NEW_IMAGE across a whole handshake
    add(1, 1, 20, 1, 0, 11);
    add(0, 0, 20, 0, 0, 11);
    add(0, 1, 30, 1, 1, 30);
    add(0, 0, 30, 0, 1, 30);
    add(1, 0,  0, 0, 0, 30);  // NEW_IMAGE held several cycles
    add(1, 1, 40, 1, 0, 30);
    add(1, 1, 40, 1, 0, 30);
    add(1, 0, 40, 0, 0, 30);
    add(0, 1, 41, 1, 1, 41);
    add(0, 0, 41, 0, 1, 41);

    RST         = 1'b0;
    NEW_IMAGE   = 1'b0;
    AEROUT_REQ  = 1'b0;
    AEROUT_ADDR = '0;
    repeat (2) @(posedge CLK);
    #1;
    check_all("reset", 0, 1'b0, 1'b0, 8'd0);
    @(negedge CLK);
    RST = 1'b1;
    @(posedge CLK);
    #1;
    check_all("post_reset", 0, 1'b0, 1'b0, 8'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      NEW_IMAGE   = vecs[i].ni;
      AEROUT_REQ  = vecs[i].req;
      AEROUT_ADDR = vecs[i].addr;
      @(posedge CLK);
      #1;
      check_all("vec", i, vecs[i].exp_ack, vecs[i].exp_done, vecs[i].exp_digit);
    end

    // Reset mid-handshake, REQ still high at release: treated as a new event.
    NEW_IMAGE   = 1'b0;
    AEROUT_REQ  = 1'b1;
    AEROUT_ADDR = 8'd200;
    @(posedge CLK);
    #1;
    check_all("mid_hs", 0, 1'b1, 1'b1, 8'd41);
    #1;
    RST = 1'b0;
    #1;
    check_all("async_rst", 0, 1'b0, 1'b0, 8'd0);
    @(posedge CLK);
    #1;
    check_all("async_rst", 1, 1'b0, 1'b0, 8'd0);
    @(negedge CLK);
    RST = 1'b1;
    @(posedge CLK);
    #1;
    check_all("rst_release", 0, 1'b1, 1'b1, 8'd200);
    AEROUT_REQ = 1'b0;
    @(posedge CLK);
    #1;
    check_all("rst_release", 1, 1'b0, 1'b1, 8'd200);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
